fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 184 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one-outstanding memory request FSM feeding a
// small in-order fetch buffer, with two-slot branch redirect and pipeline hold.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stop,
  input  logic        br0_flag,
  input  logic        br1_flag,
  input  logic        br0_num,
  input  logic        br1_num,
  input  logic [31:0] br0_address,
  input  logic [31:0] br1_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_npc,
  output logic [31:0] out_inst,
  output logic        out_num
);

  localparam int PW = $clog2(FB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FB_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        num;
  } entry_t;

  state_e         state_q, state_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [31:0]    req_addr_q, req_addr_d;
  logic           tag_q, tag_d;
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  entry_t         fb_q [FB_DEPTH];

  logic           redirect;
  logic           sel1;
  logic [31:0]    redirect_pc;
  logic           enq;
  logic           deq;
  logic           issue;
  logic           has_head;
  entry_t         wr_entry;
  entry_t         head_entry;

  // Slot 1 wins only when it alone is valid, or both are valid and it holds
  // the older tag (0) while the tags differ; every tie goes to slot 0.
  assign redirect    = br0_flag | br1_flag;
  assign sel1        = br1_flag & (~br0_flag | ((br0_num != br1_num) & ~br1_num));
  assign redirect_pc = (sel1 ? br1_address : br0_address) & ~32'h3;

  assign has_head  = (count_q != '0);
  assign out_valid = has_head & ~stop;
  assign enq       = (state_q == S_WAIT) & imem_ack & ~redirect;
  assign deq       = out_valid & out_ready & ~redirect;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    tag_d      = tag_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    issue      = 1'b0;

    if (redirect) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      tag_d      = 1'b0;
      fetch_pc_d = redirect_pc;
    end else begin
      if (enq) begin
        tail_d = tail_q + 1'b1;
        tag_d  = ~tag_q;
      end
      if (deq) begin
        head_d = head_q + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (!redirect && !stop && (count_q < DEPTH_C)) begin
          issue = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          // Back-to-back issue counts the entry being enqueued this cycle.
          if (!redirect && !stop && (count_d < DEPTH_C)) begin
            issue = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      state_d    = S_WAIT;
      req_addr_d = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      tag_q      <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      tag_q      <= tag_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  assign wr_entry = '{pc: req_addr_q, inst: imem_rdata, num: tag_q};

  // NOTE: buffer storage has no reset; count_q gates every read, so stale
  // contents are never observable and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (enq) begin
      fb_q[tail_q] <= wr_entry;
    end
  end

  assign head_entry = fb_q[head_q];

  // The idle-state request is combinational so it can go out the first cycle
  // after reset release or after a redirect; reset forces it low.
  assign imem_req  = rst_n & ((state_q != S_IDLE) | issue);
  assign imem_addr = (state_q == S_IDLE) ? fetch_pc_q : req_addr_q;

  assign out_pc   = has_head ? head_entry.pc : 32'h0;
  assign out_npc  = has_head ? (head_entry.pc + 32'd4) : 32'h0;
  assign out_inst = has_head ? head_entry.inst : 32'h0;
  assign out_num  = has_head & head_entry.num;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: a latency-programmable memory
// responder plus a linear sequence of stimulus steps with immediate assertions.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stop;
  logic        br0_flag, br1_flag;
  logic        br0_num, br1_num;
  logic [31:0] br0_address, br1_address;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc, out_npc, out_inst;
  logic        out_num;

  int tests = 0;
  int fails = 0;
  int mem_lat = 1;
  int mem_wait = 0;

  logic        req_s, ack_s, rst_s;
  logic [31:0] addr_s;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .FB_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stop(stop),
    .br0_flag(br0_flag),
    .br1_flag(br1_flag),
    .br0_num(br0_num),
    .br1_num(br1_num),
    .br0_address(br0_address),
    .br1_address(br1_address),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_npc(out_npc),
    .out_inst(out_inst),
    .out_num(out_num)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  // Memory responder: acks a request mem_lat cycles after it is first seen.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      req_s  = imem_req;
      addr_s = imem_addr;
      ack_s  = imem_ack;
      rst_s  = rst_n;
      #1;
      if (!rst_s) begin
        mem_wait = 0;
        imem_ack = 1'b0;
      end else if (ack_s) begin
        mem_wait = 0;
        imem_ack = 1'b0;
      end else if (req_s) begin
        mem_wait++;
        if (mem_wait >= mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = inst_of(addr_s);
        end
      end else begin
        mem_wait = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
  endtask

  task automatic check_out(input string tag, input logic [31:0] pc, input logic num);
    check({tag, "_pc"},   out_pc,   pc);
    check({tag, "_npc"},  out_npc,  pc + 32'd4);
    check({tag, "_inst"}, out_inst, inst_of(pc));
    check({tag, "_num"},  {31'b0, out_num}, {31'b0, num});
  endtask

  task automatic clear_br();
    br0_flag = 1'b0;
    br1_flag = 1'b0;
    br0_num  = 1'b0;
    br1_num  = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    stop        = 1'b0;
    out_ready   = 1'b1;
    br0_address = 32'h0;
    br1_address = 32'h0;
    clear_br();

    // Reset values
    repeat (3) tick();
    check("rst_req",   {31'b0, imem_req}, 32'd0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_pc",    out_pc, 32'h0);
    check("rst_npc",   out_npc, 32'h0);
    check("rst_inst",  out_inst, 32'h0);
    check("rst_num",   {31'b0, out_num}, 32'd0);

    // Streaming with 1-cycle acks and out_ready=1
    rst_n = 1'b1;
    #1;
    check("rel_req",  {31'b0, imem_req}, 32'd1);
    check("rel_addr", imem_addr, 32'h0);
    tick();
    check("ack_cycle_valid", {31'b0, out_valid}, 32'd0);
    check("ack_cycle_addr",  imem_addr, 32'h0);
    tick();
    check("lat_valid", {31'b0, out_valid}, 32'd1);
    check_out("s0", 32'h0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      wait_out("stream");
      check_out("stream", 32'(4 * k), k[0]);
    end

    // Reset mid-request
    rst_n = 1'b0;
    #1;
    check("midrst_req",   {31'b0, imem_req}, 32'd0);
    check("midrst_addr",  imem_addr, 32'h0);
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_pc",    out_pc, 32'h0);

    // Fill with out_ready=0, then drain
    out_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check("rel2_req",  {31'b0, imem_req}, 32'd1);
    check("rel2_addr", imem_addr, 32'h0);
    repeat (14) tick();
    check("full_req",   {31'b0, imem_req}, 32'd0);
    check("full_valid", {31'b0, out_valid}, 32'd1);
    check_out("full_head", 32'h0, 1'b0);
    repeat (3) tick();
    check("full_req_hold", {31'b0, imem_req}, 32'd0);
    check("full_pc_hold",  out_pc, 32'h0);
    out_ready = 1'b1;
    tick();
    check_out("drain1", 32'h4, 1'b1);
    check("drain_req",  {31'b0, imem_req}, 32'd1);
    check("drain_addr", imem_addr, 32'h10);
    tick();
    check_out("drain2", 32'h8, 1'b0);
    tick();
    check_out("drain3", 32'hC, 1'b1);
    tick();
    wait_out("drain4");
    check_out("drain4", 32'h10, 1'b0);

    // Redirect while a 2-cycle request is outstanding
    rst_n   = 1'b0;
    mem_lat = 2;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("r35_req",   {31'b0, imem_req}, 32'd1);
    check("r35_valid", {31'b0, out_valid}, 32'd0);
    br0_flag    = 1'b1;
    br0_num     = 1'b1;
    br0_address = 32'h103;
    tick();
    check("drop_req",  {31'b0, imem_req}, 32'd1);
    check("drop_addr", imem_addr, 32'h0);
    clear_br();
    tick();
    check("drop_valid",  {31'b0, out_valid}, 32'd0);
    check("redir_req",   {31'b0, imem_req}, 32'd1);
    check("redir_addr",  imem_addr, 32'h100);
    wait_out("redir");
    check_out("redir", 32'h100, 1'b0);

    // Both slots, different tags: slot with num 0 wins
    br0_flag = 1'b1; br0_num = 1'b1; br0_address = 32'h200;
    br1_flag = 1'b1; br1_num = 1'b0; br1_address = 32'h300;
    tick();
    clear_br();
    check("arb_flush_valid", {31'b0, out_valid}, 32'd0);
    wait_out("arb_num");
    check_out("arb_num", 32'h300, 1'b0);

    // Both slots, equal tags: slot 0 wins
    br0_flag = 1'b1; br0_num = 1'b1; br0_address = 32'h400;
    br1_flag = 1'b1; br1_num = 1'b1; br1_address = 32'h500;
    tick();
    clear_br();
    check("arb_eq_flush", {31'b0, out_valid}, 32'd0);
    wait_out("arb_eq");
    check_out("arb_eq", 32'h400, 1'b0);

    // Slot 1 alone, unaligned target; fill buffer for the hold test
    br0_flag = 1'b0; br0_num = 1'b0; br0_address = 32'h700;
    br1_flag = 1'b1; br1_num = 1'b1; br1_address = 32'h50A;
    out_ready = 1'b0;
    tick();
    clear_br();
    check("br1_flush", {31'b0, out_valid}, 32'd0);
    repeat (30) tick();
    check("br1_full_req", {31'b0, imem_req}, 32'd0);
    check_out("br1", 32'h508, 1'b0);

    // Stop holds the head and blocks requests
    stop      = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stop_valid", {31'b0, out_valid}, 32'd0);
      check("stop_req",   {31'b0, imem_req}, 32'd0);
    end
    stop = 1'b0;
    #1;
    check("unstop_valid", {31'b0, out_valid}, 32'd1);
    check_out("unstop_head", 32'h508, 1'b0);
    stop        = 1'b1;
    br0_flag    = 1'b1;
    br0_address = 32'h600;
    tick();
    clear_br();
    check("stop_redir_valid", {31'b0, out_valid}, 32'd0);
    check("stop_redir_req",   {31'b0, imem_req}, 32'd0);
    stop = 1'b0;
    #1;
    check("post_stop_req",   {31'b0, imem_req}, 32'd1);
    check("post_stop_addr",  imem_addr, 32'h600);
    check("post_stop_valid", {31'b0, out_valid}, 32'd0);
    wait_out("post_stop");
    check_out("post_stop", 32'h600, 1'b0);

    // Address wrap at the top of memory
    br0_flag    = 1'b1;
    br0_address = 32'hFFFF_FFFC;
    tick();
    clear_br();
    wait_out("wrap");
    check_out("wrap", 32'hFFFF_FFFC, 1'b0);
    check("wrap_npc",  out_npc, 32'h0);
    check("wrap_req",  {31'b0, imem_req}, 32'd1);
    check("wrap_addr", imem_addr, 32'h0);
    tick();
    wait_out("wrap_next");
    check_out("wrap_next", 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
